// File: rtl/dmem_lsu_if.sv
// rtl/dmem_lsu_if.sv - request/response bundle between the MEM stage and dmem_lsu
//
// Purpose: groups the load/store request handshake and the registered response.
// Ports (signals):
//   req_valid, req_ready  request handshake; accepted when both are high
//   req_we                1 = store, 0 = load
//   req_size              0 byte, 1 half, 2 word, 3 double
//   req_unsigned          load extension select (1 = zero, 0 = sign)
//   req_addr              byte address
//   req_wdata             store data, right-justified
//   resp_valid            response for the request accepted on the previous edge
//   resp_rdata            extended load data (0 for stores and errors)
//   resp_err              misaligned or illegal-size request
// Modports: master = requester (MEM stage), slave = dmem_lsu.
interface dmem_lsu_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - byte-addressable data memory with sized, extended loads/stores
//
// Purpose: data RAM for the CPU load/store path. Byte-lane stores, sign/zero
// extended loads, misalignment detection, one-cycle registered response, and an
// optional zero-fill sweep after reset.
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of dmem_lsu_if (request handshake + response)
module dmem_lsu #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic     clk,
  input  logic     rst_n,
  dmem_lsu_if.slave bus
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = ADDR_WIDTH - OFF_W;
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic {
    S_CLEAR,
    S_RUN
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [IDX_W-1:0]      clr_cnt;
  logic                  clr_we;
  logic                  ready;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [IDX_W-1:0]      idx;
  logic [OFF_W-1:0]      off;
  logic [3:0]            nbytes;
  logic [3:0]            off_ext;
  logic                  err;
  logic                  accept;
  logic [BYTES-1:0]      lane;
  logic [DATA_WIDTH-1:0] wdata_sh;
  logic [DATA_WIDTH-1:0] field;
  logic [DATA_WIDTH-1:0] keep;
  logic                  msb;
  logic [DATA_WIDTH-1:0] load_data;

  assign idx     = bus.req_addr[ADDR_WIDTH-1:OFF_W];
  assign off     = bus.req_addr[OFF_W-1:0];
  assign nbytes  = 4'd1 << bus.req_size;
  assign off_ext = 4'(off);

  // Misaligned when the offset is not a multiple of the access size; sizes
  // wider than the word are illegal regardless of alignment.
  assign err    = (int'(nbytes) > BYTES) || ((off_ext & (nbytes - 4'd1)) != 4'd0);
  assign accept = bus.req_valid && ready;

  always_comb begin
    lane = '0;
    for (int b = 0; b < BYTES; b++) begin
      lane[b] = (b >= int'(off)) && (b < int'(off) + int'(nbytes));
    end
  end

  assign wdata_sh = bus.req_wdata << {off, 3'b000};

  // Combinational read: a store committed on the previous edge is already
  // visible, so store-then-load to the same word needs no bypass.
  assign field = mem[idx] >> {off, 3'b000};

  always_comb begin
    keep = '1;
    msb  = field[DATA_WIDTH-1];
    case (bus.req_size)
      2'd0: begin
        keep = DATA_WIDTH'(8'hff);
        msb  = field[7];
      end
      2'd1: begin
        keep = DATA_WIDTH'(16'hffff);
        msb  = field[15];
      end
      2'd2: begin
        keep = DATA_WIDTH'(32'hffff_ffff);
        msb  = field[31];
      end
      default: begin
        keep = '1;
        msb  = field[DATA_WIDTH-1];
      end
    endcase
    load_data = (field & keep) | ((msb && !bus.req_unsigned) ? ~keep : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (clr_we) begin
        clr_cnt <= clr_cnt + IDX_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    clr_we    = 1'b0;
    case (state)
      S_CLEAR: begin
        clr_we = 1'b1;
        if (clr_cnt == IDX_W'(DEPTH - 1)) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        ready = 1'b1;
      end
      default: begin
        state_nxt = S_RUN;
      end
    endcase
  end

  assign bus.req_ready = ready;

  // RAM has no reset; only the clear sweep initialises it. The sweep and
  // request writes never coincide because ready is low during CLEAR.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt] <= '0;
    end else if (accept && bus.req_we && !err) begin
      for (int b = 0; b < BYTES; b++) begin
        if (lane[b]) begin
          mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.resp_rdata <= '0;
    end else begin
      bus.resp_valid <= accept;
      bus.resp_err   <= accept && err;
      bus.resp_rdata <= (accept && !bus.req_we && !err) ? load_data : '0;
    end
  end
endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - self-checking bench for dmem_lsu with a byte-array reference model
module tb_dmem_lsu;
  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int BYTES = DW / 8;
  localparam int DEPTH = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_lsu_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  dmem_lsu #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int         pass_cnt  = 0;
  int         total_cnt = 0;
  logic [7:0] ref_mem [256];

  task automatic model_zero();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
  endtask

  // Reference: memory is a flat byte array, little-endian; loads assemble
  // bytes as an integer and sign-extend by subtracting 2^(8n).
  task automatic model_access(input bit we, input logic [1:0] size, input bit uns,
                              input logic [7:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rdata, output logic err);
    int     n;
    longint v;
    n     = 1 << size;
    err   = (n > BYTES) || ((int'(addr) % n) != 0);
    rdata = 32'h0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < n; i++) ref_mem[int'(addr) + i] = 8'((wdata >> (8 * i)) & 32'hff);
      end else begin
        v = 0;
        for (int i = 0; i < n; i++) v = v + (longint'(ref_mem[int'(addr) + i]) << (8 * i));
        if (!uns && n < BYTES && (((v >> (8 * n - 1)) & 1) == 1)) v = v - (longint'(1) << (8 * n));
        rdata = 32'(v);
      end
    end
  endtask

  task automatic idle_inputs();
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
  endtask

  task automatic do_req(input bit we, input logic [1:0] size, input bit uns,
                        input logic [7:0] addr, input logic [31:0] wdata,
                        output logic rv, output logic [31:0] rd, output logic er);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    @(posedge clk);
    #1;
    rv = bus.resp_valid;
    rd = bus.resp_rdata;
    er = bus.resp_err;
    idle_inputs();
  endtask

  task automatic wait_clear(output int edges);
    edges = 0;
    while (edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
      if (bus.req_ready) break;
    end
  endtask

  task automatic test_reset();
    int          edges;
    logic        rv, er;
    logic [31:0] rd;
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_rdata} !== {3'b000, 32'h0})
      $display("FAIL reset_values: got ready=%b valid=%b err=%b rdata=%h, expected 0 0 0 00000000",
               bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_rdata);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    wait_clear(edges);
    total_cnt++;
    if (edges !== DEPTH) $display("FAIL clear_latency: got %0d edges, expected %0d", edges, DEPTH);
    else pass_cnt++;
    model_zero();
    for (int w = 0; w < DEPTH; w++) begin
      do_req(1'b0, 2'd2, 1'b0, 8'(w * 4), 32'h0, rv, rd, er);
      total_cnt++;
      if ({rv, er, rd} !== {2'b10, 32'h0})
        $display("FAIL cleared_word_%0d: got v=%b e=%b d=%h, expected v=1 e=0 d=00000000", w, rv, er, rd);
      else pass_cnt++;
    end
  endtask

  task automatic test_sign_ext();
    logic        rv, er, me;
    logic [31:0] rd, md;
    do_req(1'b1, 2'd2, 1'b0, 8'h10, 32'hDEADBEEF, rv, rd, er);
    model_access(1'b1, 2'd2, 1'b0, 8'h10, 32'hDEADBEEF, md, me);
    total_cnt++;
    if ({rv, er, rd} !== {2'b10, 32'h0})
      $display("FAIL store_word_resp: got v=%b e=%b d=%h, expected v=1 e=0 d=00000000", rv, er, rd);
    else pass_cnt++;
    do_req(1'b0, 2'd0, 1'b0, 8'h11, 32'h0, rv, rd, er);
    total_cnt++;
    if ({rv, er, rd} !== {2'b10, 32'hFFFFFFBE})
      $display("FAIL byte_signed: got v=%b e=%b d=%h, expected v=1 e=0 d=ffffffbe", rv, er, rd);
    else pass_cnt++;
    do_req(1'b0, 2'd0, 1'b1, 8'h11, 32'h0, rv, rd, er);
    total_cnt++;
    if ({rv, er, rd} !== {2'b10, 32'h000000BE})
      $display("FAIL byte_unsigned: got v=%b e=%b d=%h, expected v=1 e=0 d=000000be", rv, er, rd);
    else pass_cnt++;
    do_req(1'b0, 2'd1, 1'b0, 8'h12, 32'h0, rv, rd, er);
    total_cnt++;
    if ({rv, er, rd} !== {2'b10, 32'hFFFFDEAD})
      $display("FAIL half_signed: got v=%b e=%b d=%h, expected v=1 e=0 d=ffffdead", rv, er, rd);
    else pass_cnt++;
    do_req(1'b0, 2'd1, 1'b1, 8'h12, 32'h0, rv, rd, er);
    total_cnt++;
    if ({rv, er, rd} !== {2'b10, 32'h0000DEAD})
      $display("FAIL half_unsigned: got v=%b e=%b d=%h, expected v=1 e=0 d=0000dead", rv, er, rd);
    else pass_cnt++;
  endtask

  task automatic test_byte_lane();
    logic        rv, er, me;
    logic [31:0] rd, md;
    // Upper bits of wdata are junk and must not reach other lanes.
    do_req(1'b1, 2'd0, 1'b0, 8'h13, 32'hFFFFFF5A, rv, rd, er);
    model_access(1'b1, 2'd0, 1'b0, 8'h13, 32'hFFFFFF5A, md, me);
    do_req(1'b0, 2'd2, 1'b0, 8'h10, 32'h0, rv, rd, er);
    total_cnt++;
    if ({rv, er, rd} !== {2'b10, 32'h5AADBEEF})
      $display("FAIL byte_lane_store: got v=%b e=%b d=%h, expected v=1 e=0 d=5aadbeef", rv, er, rd);
    else pass_cnt++;
  endtask

  task automatic test_misalign();
    logic        rv, er, me;
    logic [31:0] rd, md;
    do_req(1'b1, 2'd2, 1'b0, 8'h20, 32'hCAFEF00D, rv, rd, er);
    model_access(1'b1, 2'd2, 1'b0, 8'h20, 32'hCAFEF00D, md, me);
    do_req(1'b1, 2'd1, 1'b0, 8'h21, 32'h0000FFFF, rv, rd, er);
    total_cnt++;
    if ({rv, er, rd} !== {2'b11, 32'h0})
      $display("FAIL misaligned_half_store: got v=%b e=%b d=%h, expected v=1 e=1 d=00000000", rv, er, rd);
    else pass_cnt++;
    do_req(1'b0, 2'd2, 1'b0, 8'h20, 32'h0, rv, rd, er);
    total_cnt++;
    if ({rv, er, rd} !== {2'b10, 32'hCAFEF00D})
      $display("FAIL ram_unchanged_after_err: got v=%b e=%b d=%h, expected v=1 e=0 d=cafef00d", rv, er, rd);
    else pass_cnt++;
    do_req(1'b0, 2'd2, 1'b0, 8'h22, 32'h0, rv, rd, er);
    total_cnt++;
    if ({rv, er, rd} !== {2'b11, 32'h0})
      $display("FAIL misaligned_word_load: got v=%b e=%b d=%h, expected v=1 e=1 d=00000000", rv, er, rd);
    else pass_cnt++;
    do_req(1'b1, 2'd3, 1'b0, 8'h20, 32'h11111111, rv, rd, er);
    total_cnt++;
    if ({rv, er, rd} !== {2'b11, 32'h0})
      $display("FAIL size3_store: got v=%b e=%b d=%h, expected v=1 e=1 d=00000000", rv, er, rd);
    else pass_cnt++;
    do_req(1'b0, 2'd3, 1'b0, 8'h20, 32'h0, rv, rd, er);
    total_cnt++;
    if ({rv, er, rd} !== {2'b11, 32'h0})
      $display("FAIL size3_load: got v=%b e=%b d=%h, expected v=1 e=1 d=00000000", rv, er, rd);
    else pass_cnt++;
    do_req(1'b0, 2'd2, 1'b0, 8'h20, 32'h0, rv, rd, er);
    total_cnt++;
    if (rd !== 32'hCAFEF00D)
      $display("FAIL ram_unchanged_after_size3: got d=%h, expected d=cafef00d", rd);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic        me;
    logic [31:0] md;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'd2;
    bus.req_addr  = 8'h30;
    bus.req_wdata = 32'h12345678;
    @(posedge clk);
    #1;
    model_access(1'b1, 2'd2, 1'b0, 8'h30, 32'h12345678, md, me);
    total_cnt++;
    if ({bus.resp_valid, bus.resp_err, bus.resp_rdata} !== {2'b10, 32'h0})
      $display("FAIL b2b_store_resp: got v=%b e=%b d=%h, expected v=1 e=0 d=00000000",
               bus.resp_valid, bus.resp_err, bus.resp_rdata);
    else pass_cnt++;
    bus.req_we    = 1'b0;
    bus.req_wdata = 32'h0;
    @(posedge clk);
    #1;
    total_cnt++;
    if ({bus.resp_valid, bus.resp_err, bus.resp_rdata} !== {2'b10, 32'h12345678})
      $display("FAIL b2b_load_resp: got v=%b e=%b d=%h, expected v=1 e=0 d=12345678",
               bus.resp_valid, bus.resp_err, bus.resp_rdata);
    else pass_cnt++;
    idle_inputs();
    @(posedge clk);
    #1;
    total_cnt++;
    if (bus.resp_valid !== 1'b0)
      $display("FAIL b2b_valid_drop: got v=%b, expected v=0", bus.resp_valid);
    else pass_cnt++;
  endtask

  task automatic test_random();
    bit          v, we, uns;
    logic [1:0]  size;
    logic [7:0]  addr;
    logic [31:0] wdata, md;
    logic        me;
    for (int it = 0; it < 400; it++) begin
      v     = ($urandom_range(0, 4) != 0);
      we    = $urandom_range(0, 1) == 1;
      uns   = $urandom_range(0, 1) == 1;
      size  = 2'($urandom_range(0, 3));
      addr  = 8'($urandom_range(0, 255));
      wdata = $urandom;
      if ($urandom_range(0, 3) != 0 && size != 2'd3) addr = addr & ~8'((1 << size) - 1);
      bus.req_valid    = v;
      bus.req_we       = we;
      bus.req_size     = size;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wdata;
      @(posedge clk);
      #1;
      total_cnt++;
      if (v) begin
        model_access(we, size, uns, addr, wdata, md, me);
        if ({bus.resp_valid, bus.resp_err, bus.resp_rdata} !== {1'b1, me, md})
          $display("FAIL random_%0d we=%b sz=%0d u=%b a=%h: got v=%b e=%b d=%h, expected v=1 e=%b d=%h",
                   it, we, size, uns, addr, bus.resp_valid, bus.resp_err, bus.resp_rdata, me, md);
        else pass_cnt++;
      end else begin
        if (bus.resp_valid !== 1'b0)
          $display("FAIL random_idle_%0d: got v=%b, expected v=0", it, bus.resp_valid);
        else pass_cnt++;
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_midway();
    int          edges;
    logic        rv, er;
    logic [31:0] rd;
    // Reset while an error response is being presented.
    bus.req_valid = 1'b1;
    bus.req_size  = 2'd2;
    bus.req_addr  = 8'h22;
    @(posedge clk);
    #1;
    idle_inputs();
    total_cnt++;
    if ({bus.resp_valid, bus.resp_err} !== 2'b11)
      $display("FAIL pre_reset_err_resp: got v=%b e=%b, expected v=1 e=1", bus.resp_valid, bus.resp_err);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_rdata} !== {3'b000, 32'h0})
      $display("FAIL async_reset_resp: got ready=%b v=%b e=%b d=%h, expected 0 0 0 00000000",
               bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_rdata);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    wait_clear(edges);
    total_cnt++;
    if (edges !== DEPTH) $display("FAIL clear_latency_after_resp_reset: got %0d, expected %0d", edges, DEPTH);
    else pass_cnt++;
    // Dirty a word, then reset partway through the next sweep.
    do_req(1'b1, 2'd2, 1'b0, 8'h40, 32'hA5A5A5A5, rv, rd, er);
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    total_cnt++;
    if (bus.req_ready !== 1'b0) $display("FAIL ready_mid_clear: got %b, expected 0", bus.req_ready);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_rdata} !== {3'b000, 32'h0})
      $display("FAIL reset_mid_clear_values: got ready=%b v=%b e=%b d=%h, expected 0 0 0 00000000",
               bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_rdata);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    wait_clear(edges);
    total_cnt++;
    if (edges !== DEPTH) $display("FAIL clear_latency_after_mid_clear: got %0d, expected %0d", edges, DEPTH);
    else pass_cnt++;
    model_zero();
    do_req(1'b0, 2'd2, 1'b0, 8'h40, 32'h0, rv, rd, er);
    total_cnt++;
    if ({rv, er, rd} !== {2'b10, 32'h0})
      $display("FAIL resweep_word_40: got v=%b e=%b d=%h, expected v=1 e=0 d=00000000", rv, er, rd);
    else pass_cnt++;
    do_req(1'b0, 2'd2, 1'b0, 8'h30, 32'h0, rv, rd, er);
    total_cnt++;
    if ({rv, er, rd} !== {2'b10, 32'h0})
      $display("FAIL resweep_word_30: got v=%b e=%b d=%h, expected v=1 e=0 d=00000000", rv, er, rd);
    else pass_cnt++;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_sign_ext();
    test_byte_lane();
    test_misalign();
    test_back_to_back();
    test_random();
    test_reset_midway();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Byte-addressable data memory for the CPU load/store path, successor to the plain word-wide data RAM. It supports sized stores through byte-lane enables and sized loads with sign or zero extension. It detects misaligned accesses, returns a registered response one cycle after each accepted request, and can zero-fill its contents after reset under a clear state machine. It sits between the MEM pipeline stage and the register-file writeback mux.

## Interface
- DATA_WIDTH, 32, word width in bits; legal values 32 or 64. BYTES = DATA_WIDTH/8.
- ADDR_WIDTH, 8, byte-address width. DEPTH = 2**(ADDR_WIDTH - log2(BYTES)) words.
- CLEAR_ON_RESET, 1, when 1, zero-fill the RAM after reset before accepting requests.

- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request present this cycle.
- req_ready  out  1  block accepts a request this cycle. A request is accepted when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double (legal only when DATA_WIDTH = 64).
- req_unsigned  in  1  load extension: 1 = zero-extend, 0 = sign-extend. Ignored for stores and for full-width loads.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-justified in the low 8·2^size bits.
- resp_valid  out  1  response for the request accepted on the previous edge.
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- resp_err  out  1  request was misaligned or had an illegal size.

## Operation
- FSM states:
  - CLEAR: req_ready = 0. Writes 0 to word clr_cnt on each edge, then increments clr_cnt. Moves to RUN on the edge that writes word DEPTH-1.
  - RUN: req_ready = 1.
- Reset state: CLEAR when CLEAR_ON_RESET = 1, RUN otherwise. clr_cnt resets to 0.
- Word index = req_addr[ADDR_WIDTH-1 : log2(BYTES)]. Byte offset = the low log2(BYTES) bits.
- Error condition: (offset mod 2^size) != 0, or 2^size > BYTES. On error:
  - no RAM write;
  - resp_err = 1, resp_rdata = 0.
- Store without error:
  - lane mask = ((1 << 2^size) − 1) << offset;
  - data = req_wdata << (8·offset);
  - only masked bytes of the addressed word are updated on the accepting edge.
- Load without error:
  - field = (word >> 8·offset), low 8·2^size bits;
  - upper bits are filled with the field MSB (signed) or 0 (unsigned).
- Every accepted request produces exactly one response on the following cycle; stores respond with rdata 0, err 0.
- Responses have no backpressure; the consumer must take resp_* in the cycle resp_valid is high.
- RAM contents are not reset by rst_n except through the CLEAR sweep.

## Timing
- Reset values: req_ready = 0 (1 if CLEAR_ON_RESET = 0), resp_valid = 0, resp_rdata = 0, resp_err = 0.
- Clear latency: req_ready rises after exactly DEPTH rising edges following rst_n deassertion.
- Load/store latency: request accepted at edge N; resp_* valid from edge N until edge N+1. resp_valid drops at edge N+1 if no request is accepted at N+1.
- Throughput: one request per cycle in RUN.
- Store at edge N followed by a load to the same word at edge N+1: the load returns the updated data. No same-cycle read-during-write case exists.
- A reset asserted mid-CLEAR or mid-response clears resp_valid and resp_err immediately (async) and restarts the sweep from word 0.
- Address wrap: there is none; ADDR_WIDTH exactly covers DEPTH·BYTES bytes.

## Test plan
- Reset clear, DATA_WIDTH = 32, ADDR_WIDTH = 8 (DEPTH 64): req_ready = 0 for 64 edges, then 1. A word load of every word returns 0x00000000.
- Sign extension:
  - store word 0xDEADBEEF at 0x10;
  - byte load signed at 0x11 → 0xFFFFFFBE;
  - byte load unsigned at 0x11 → 0x000000BE;
  - half load signed at 0x12 → 0xFFFFDEAD.
- Byte-lane store: after the word above, store byte 0x5A at 0x13, then word load at 0x10 → 0x5AADBEEF.
- Misalignment:
  - half store at 0x21 → resp_err = 1, RAM unchanged (word load at 0x20 returns prior value, err 0);
  - word load at 0x22 → err 1, rdata 0;
  - size 3 with DATA_WIDTH = 32 → err 1.
- Back-to-back: word store 0x12345678 at 0x30 on edge N, word load 0x30 on edge N+1 → resp_rdata = 0x12345678 in cycle N+2. resp_valid stays high for both responses.
- Reset mid-clear: assert rst_n low at clear word 20 → outputs return to reset values at once. After release, req_ready rises again after a full 64 edges.
